// File: rtl/xor_mpram_pkg.sv
// Shared types and helpers for the XOR multi-port RAM.
// - state_e:      init sweep / normal operation
// - num_banks:    total bank count for a given port configuration
// - wr_bank_idx:  bank of write port `owner` whose read side follows write port `other`
// - rd_bank_idx:  bank of write port `owner` whose read side follows read port `rd`
package xor_mpram_pkg;

  typedef enum logic {
    StInit  = 1'b0,
    StReady = 1'b1
  } state_e;

  function automatic int unsigned banks_per_wr(int unsigned nw, int unsigned nr);
    return nw - 1 + nr;
  endfunction

  function automatic int unsigned num_banks(int unsigned nw, int unsigned nr);
    return nw * banks_per_wr(nw, nr);
  endfunction

  // Never called with other == owner: a port does not read its own banks.
  function automatic int unsigned wr_bank_idx(int unsigned owner, int unsigned other,
                                              int unsigned nw, int unsigned nr);
    return owner * banks_per_wr(nw, nr) + ((other < owner) ? other : other - 1);
  endfunction

  function automatic int unsigned rd_bank_idx(int unsigned owner, int unsigned rd,
                                              int unsigned nw, int unsigned nr);
    return owner * banks_per_wr(nw, nr) + (nw - 1) + rd;
  endfunction

endpackage

// File: rtl/xor_mpram_if.sv
// Bus bundle for xor_mpram.
// - wr_en/wr_addr/wr_data: per write port, port p at slice p
// - rd_addr/rd_data:       per read port, port r at slice r
// - busy:                  init sweep in progress
// - wr_collision:          sticky same-cycle same-address write flag
// master = requester side, slave = memory side.
interface xor_mpram_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_WR     = 4,
  parameter int unsigned NUM_RD     = 4
);
  logic [NUM_WR-1:0]            wr_en;
  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic                         busy;
  logic                         wr_collision;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, busy, wr_collision
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, busy, wr_collision
  );
endinterface

// File: rtl/xor_sdp_bank.sv
// Simple dual-port bank RAM: one write port, one registered read port.
// A same-address read and write on one edge returns the old word. No reset.
// - clk:     clock
// - i_we/i_waddr/i_wdata: write port
// - i_raddr: read address, o_rdata registered
module xor_sdp_bank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/xor_mpram.sv
// XOR-based multi-port RAM: NUM_WR write ports, NUM_RD read ports built from
// simple dual-port banks. The stored word is the XOR of every write port's bank.
// Ports:
// - clk, rst: clock and asynchronous active-high reset
// - bus (xor_mpram_if.slave): write/read ports, busy, wr_collision
// Build option: define XOR_MPRAM_BYPASS_EN for read-after-write bypass so a read
// returns the newest write sampled at or before its own edge.
module xor_mpram
  import xor_mpram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_WR     = 4,
  parameter int unsigned NUM_RD     = 4
) (
  input logic       clk,
  input logic       rst,
  xor_mpram_if.slave bus
);
  localparam int unsigned BanksPerWr = banks_per_wr(NUM_WR, NUM_RD);
  localparam int unsigned NumBanks   = num_banks(NUM_WR, NUM_RD);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  state_e r_state, w_state_next;
  addr_t  r_cnt;
  logic   w_init;

  addr_t w_wr_addr [NUM_WR];
  data_t w_wr_data [NUM_WR];
  addr_t w_rd_addr [NUM_RD];

  logic [NUM_WR-1:0] w_wr_win;
  logic              w_collision;
  logic              r_collision;

  // Stage-1 write registers and the word each port committed on the last edge.
  logic [NUM_WR-1:0] r_wr_en;
  addr_t             r_wr_addr [NUM_WR];
  data_t             r_wr_data [NUM_WR];
  logic [NUM_WR-1:0] r_cm_en;
  addr_t             r_cm_addr [NUM_WR];
  data_t             r_cm_word [NUM_WR];
  data_t             w_wr_word [NUM_WR];

  data_t w_bank_rdata [NumBanks];
  data_t w_rd_xor     [NUM_RD];
  data_t w_rd_next    [NUM_RD];
  data_t r_rd_data    [NUM_RD];
  logic  r_rd_gate;

  always_comb begin
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      w_wr_addr[p] = bus.wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      w_wr_data[p] = bus.wr_data[p*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      w_rd_addr[r] = bus.rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // FSM: state register / next state / outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StInit;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StInit:  if (r_cnt == LastAddr) w_state_next = StReady;
      StReady: w_state_next = StReady;
    endcase
  end

  always_comb begin
    w_init           = (r_state == StInit);
    bus.busy         = w_init;
    bus.wr_collision = r_collision;
    bus.rd_data      = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      bus.rd_data[r*DATA_WIDTH +: DATA_WIDTH] = r_rd_data[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cnt <= '0;
    else if (w_init) r_cnt <= r_cnt + 1'b1;
  end

  // Lowest enabled port wins an address; enables are ignored during the sweep.
  always_comb begin
    logic [NUM_WR-1:0] req;
    req         = w_init ? '0 : bus.wr_en;
    w_wr_win    = req;
    w_collision = 1'b0;
    for (int unsigned p = 1; p < NUM_WR; p++) begin
      for (int unsigned q = 0; q < p; q++) begin
        if (req[p] && req[q] && (w_wr_addr[p] == w_wr_addr[q])) begin
          w_wr_win[p] = 1'b0;
          w_collision = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en     <= '0;
      r_wr_addr   <= '{default: '0};
      r_wr_data   <= '{default: '0};
      r_cm_en     <= '0;
      r_cm_addr   <= '{default: '0};
      r_cm_word   <= '{default: '0};
      r_collision <= 1'b0;
    end else begin
      r_wr_en     <= w_wr_win;
      r_wr_addr   <= w_wr_addr;
      r_wr_data   <= w_wr_data;
      r_cm_en     <= r_wr_en;
      r_cm_addr   <= r_wr_addr;
      r_cm_word   <= w_wr_word;
      r_collision <= r_collision | w_collision;
    end
  end

  // Bank word = data XOR the other ports' current words at that address. The
  // banks were read one edge ago and miss a commit landing on that same edge,
  // so a just-committed word from another port overrides its stale bank output.
  always_comb begin
    for (int unsigned q = 0; q < NUM_WR; q++) begin
      data_t acc;
      acc = r_wr_data[q];
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (p != q) begin
          if (r_cm_en[p] && (r_cm_addr[p] == r_wr_addr[q])) acc ^= r_cm_word[p];
          else acc ^= w_bank_rdata[wr_bank_idx(p, q, NUM_WR, NUM_RD)];
        end
      end
      w_wr_word[q] = acc;
    end
  end

  for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
    logic  w_we;
    addr_t w_waddr;
    data_t w_wdata;

    assign w_we    = w_init | r_wr_en[p];
    assign w_waddr = w_init ? r_cnt : r_wr_addr[p];
    assign w_wdata = w_init ? '0 : w_wr_word[p];

    for (genvar j = 0; j < BanksPerWr; j++) begin : g_bank
      addr_t w_raddr;
      if (j < NUM_WR - 1) begin : g_wr_side
        // Skip the owner's own index when mapping j onto the other write ports.
        assign w_raddr = w_wr_addr[(j < p) ? j : j + 1];
      end else begin : g_rd_side
        assign w_raddr = w_rd_addr[j - (NUM_WR - 1)];
      end

      xor_sdp_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
      ) u_bank (
        .clk    (clk),
        .i_we   (w_we),
        .i_waddr(w_waddr),
        .i_wdata(w_wdata),
        .i_raddr(w_raddr),
        .o_rdata(w_bank_rdata[p*BanksPerWr + j])
      );
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      data_t acc;
      acc = '0;
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        acc ^= w_bank_rdata[rd_bank_idx(p, r, NUM_WR, NUM_RD)];
      end
      w_rd_xor[r] = acc;
    end
  end

`ifdef XOR_MPRAM_BYPASS_EN
  logic [NUM_RD-1:0] w_byp_hit, r_byp_hit;
  data_t             w_byp_data [NUM_RD];
  data_t             r_byp_data [NUM_RD];

  // Newest stage first (this edge's writes, then stage 1); lowest port first.
  always_comb begin
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      logic  hit;
      data_t dat;
      hit = 1'b0;
      dat = '0;
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (!hit && w_wr_win[p] && (w_wr_addr[p] == w_rd_addr[r])) begin
          hit = 1'b1;
          dat = w_wr_data[p];
        end
      end
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (!hit && r_wr_en[p] && (r_wr_addr[p] == w_rd_addr[r])) begin
          hit = 1'b1;
          dat = r_wr_data[p];
        end
      end
      w_byp_hit[r]  = hit;
      w_byp_data[r] = dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byp_hit  <= '0;
      r_byp_data <= '{default: '0};
    end else begin
      r_byp_hit  <= w_byp_hit;
      r_byp_data <= w_byp_data;
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      w_rd_next[r] = r_byp_hit[r] ? r_byp_data[r] : w_rd_xor[r];
    end
  end
`else
  always_comb begin
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      w_rd_next[r] = w_rd_xor[r];
    end
  end
`endif

  // r_rd_gate covers the read issued on the final sweep edge, whose bank
  // word may still be uninitialised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_gate <= 1'b1;
      r_rd_data <= '{default: '0};
    end else begin
      r_rd_gate <= w_init;
      for (int unsigned r = 0; r < NUM_RD; r++) begin
        r_rd_data[r] <= r_rd_gate ? '0 : w_rd_next[r];
      end
    end
  end

endmodule
